// File: rtl/flpv3l_mbus_rx_buffer.sv
// flpv3l_mbus_rx_buffer: MBus RX handshake with commit-on-complete message FIFO toward the layer controller
module flpv3l_mbus_rx_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [AW-1:0] RX_ADDR,
  input  logic [DW-1:0] RX_DATA,
  input  logic          RX_REQ,
  input  logic          RX_PEND,
  input  logic          RX_BROADCAST,
  input  logic          RX_FAIL,
  output logic          RX_ACK,
  output logic          MSG_VALID,
  output logic [AW-1:0] MSG_ADDR,
  output logic [DW-1:0] MSG_DATA,
  output logic          MSG_LAST,
  output logic          MSG_BCAST,
  input  logic          MSG_READY,
  output logic          OVERFLOW,
  input  logic          CLR_OVERFLOW
);
  localparam int PW = $clog2(DEPTH) + 1;
  typedef enum logic [1:0] {IDLE, ACK, DROP, DROP_ACK} state_t;
  state_t state;
  logic req_q, req_s, fail_q, fail_s, drop_last, full, pop, we;
  logic [PW-1:0] wr, cm, rd;
  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0] mem_last, mem_bcast;
  assign full = (wr - rd) == PW'(DEPTH);
  assign MSG_VALID = cm != rd;
  assign pop = MSG_VALID && MSG_READY;
  assign we = state == IDLE && req_s && !fail_s && !full;
  assign RX_ACK = state == ACK || state == DROP_ACK;
  assign MSG_ADDR = MSG_VALID ? mem_addr[rd[PW-2:0]] : '0;
  assign MSG_DATA = MSG_VALID ? mem_data[rd[PW-2:0]] : '0;
  assign MSG_LAST = MSG_VALID && mem_last[rd[PW-2:0]];
  assign MSG_BCAST = MSG_VALID && mem_bcast[rd[PW-2:0]];
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_addr[wr[PW-2:0]] <= RX_ADDR;
      mem_data[wr[PW-2:0]] <= RX_DATA;
      mem_last[wr[PW-2:0]] <= !RX_PEND;
      mem_bcast[wr[PW-2:0]] <= RX_BROADCAST;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      {req_q, req_s, fail_q, fail_s} <= '0;
      {wr, cm, rd} <= '0;
      state <= IDLE;
      drop_last <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      {req_q, req_s} <= {RX_REQ, req_q};
      {fail_q, fail_s} <= {RX_FAIL, fail_q};
      if (pop) rd <= rd + PW'(1);
      if (CLR_OVERFLOW) OVERFLOW <= 1'b0;
      case (state)
        IDLE: begin
          if (fail_s) wr <= cm;
          else if (req_s && !full) begin
            wr <= wr + PW'(1);
            if (!RX_PEND) cm <= wr + PW'(1);
            state <= ACK;
          end else if (req_s && cm == rd) begin
            wr <= cm;
            OVERFLOW <= 1'b1;
            state <= DROP;
          end
        end
        ACK: begin
          if (fail_s) wr <= cm;
          if (!req_s) state <= IDLE;
        end
        DROP: begin
          if (req_s) begin
            drop_last <= !RX_PEND || fail_s;
            state <= DROP_ACK;
          end else if (fail_s) state <= IDLE;
        end
        default: begin
          if (fail_s) drop_last <= 1'b1;
          if (!req_s) state <= (drop_last || fail_s) ? IDLE : DROP;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flpv3l_mbus_rx_buffer.sv
// tb_flpv3l_mbus_rx_buffer: scoreboard bench for the MBus RX message buffer
module tb_flpv3l_mbus_rx_buffer;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic l;
    logic b;
  } ent_t;
  logic CLK = 1'b0, RESET = 1'b1;
  logic [31:0] RX_ADDR = '0, RX_DATA = '0;
  logic RX_REQ = 1'b0, RX_PEND = 1'b0, RX_BROADCAST = 1'b0, RX_FAIL = 1'b0;
  logic RX_ACK, MSG_VALID, MSG_LAST, MSG_BCAST, OVERFLOW;
  logic [31:0] MSG_ADDR, MSG_DATA;
  logic MSG_READY = 1'b0, CLR_OVERFLOW = 1'b0;
  int n_tests = 0, n_fail = 0;
  ent_t sb[$];
  flpv3l_mbus_rx_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .CLK(CLK), .RESET(RESET), .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA), .RX_REQ(RX_REQ),
    .RX_PEND(RX_PEND), .RX_BROADCAST(RX_BROADCAST), .RX_FAIL(RX_FAIL), .RX_ACK(RX_ACK),
    .MSG_VALID(MSG_VALID), .MSG_ADDR(MSG_ADDR), .MSG_DATA(MSG_DATA), .MSG_LAST(MSG_LAST),
    .MSG_BCAST(MSG_BCAST), .MSG_READY(MSG_READY), .OVERFLOW(OVERFLOW), .CLR_OVERFLOW(CLR_OVERFLOW)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge CLK) begin
    if (!RESET && MSG_VALID && MSG_READY) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 1);
      else begin
        ent_t e;
        e = sb.pop_front();
        chk("msg_addr", MSG_ADDR, e.a);
        chk("msg_data", MSG_DATA, e.d);
        chk("msg_last", MSG_LAST, e.l);
        chk("msg_bcast", MSG_BCAST, e.b);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic send_word(input logic [31:0] a, input logic [31:0] d, input logic pend,
                           input logic bc, input logic push, input int lat);
    int n;
    if (push) sb.push_back('{a: a, d: d, l: !pend, b: bc});
    RX_ADDR = a;
    RX_DATA = d;
    RX_PEND = pend;
    RX_BROADCAST = bc;
    RX_REQ = 1'b1;
    n = 0;
    do begin tick(1); n++; end while (!RX_ACK && n < 200);
    chk("ack_rise", RX_ACK, 1);
    if (lat > 0) chk("ack_rise_lat", 64'(n), 64'(lat));
    RX_REQ = 1'b0;
    n = 0;
    do begin tick(1); n++; end while (RX_ACK && n < 200);
    chk("ack_fall", RX_ACK, 0);
    if (lat > 0) chk("ack_fall_lat", 64'(n), 3);
  endtask
  task automatic drain();
    int n;
    MSG_READY = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 100) begin tick(1); n++; end
    MSG_READY = 1'b0;
    chk("drain_empty", 64'(sb.size()), 0);
    chk("drain_valid", MSG_VALID, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick(3);
    RESET = 1'b0;
    chk("rst_ack", RX_ACK, 0);
    chk("rst_valid", MSG_VALID, 0);
    chk("rst_last", MSG_LAST, 0);
    chk("rst_bcast", MSG_BCAST, 0);
    chk("rst_addr", MSG_ADDR, 0);
    chk("rst_data", MSG_DATA, 0);
    chk("rst_ovf", OVERFLOW, 0);
    send_word(32'h0000_0012, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 3);
    chk("single_valid", MSG_VALID, 1);
    chk("single_data", MSG_DATA, 32'hDEAD_BEEF);
    drain();
    for (int i = 0; i < 3; i++) begin
      send_word(32'h100 + i, 32'hA000 + i, i < 2, 1'b1, 1'b1, 3);
      chk("three_valid", MSG_VALID, i == 2);
    end
    drain();
    send_word(32'h200, 32'hB0, 1'b1, 1'b0, 1'b0, 3);
    send_word(32'h201, 32'hB1, 1'b1, 1'b0, 1'b0, 3);
    RX_FAIL = 1'b1;
    tick(4);
    RX_FAIL = 1'b0;
    tick(4);
    chk("fail_valid", MSG_VALID, 0);
    send_word(32'h300, 32'hC0FFEE, 1'b0, 1'b0, 1'b1, 3);
    chk("fail_next_valid", MSG_VALID, 1);
    drain();
    for (int i = 0; i < 6; i++) send_word(32'h400 + i, 32'hD0 + i, i < 5, 1'b0, 1'b0, i < 4 ? 3 : -1);
    chk("ovf_set", OVERFLOW, 1);
    chk("ovf_valid", MSG_VALID, 0);
    CLR_OVERFLOW = 1'b1;
    tick(1);
    CLR_OVERFLOW = 1'b0;
    chk("ovf_clr", OVERFLOW, 0);
    for (int i = 0; i < 4; i++) send_word(32'h500 + i, 32'hE0 + i, i % 2 == 0, i[0], 1'b1, 3);
    fork
      send_word(32'h600, 32'hF00D, 1'b0, 1'b0, 1'b1, -1);
      begin
        tick(10);
        chk("stall_ack", RX_ACK, 0);
        MSG_READY = 1'b1;
        tick(1);
        MSG_READY = 1'b0;
        tick(1);
        chk("stall_release", RX_ACK, 1);
      end
    join
    drain();
    chk("stall_ovf", OVERFLOW, 0);
    send_word(32'h700, 32'h1, 1'b1, 1'b0, 1'b0, 3);
    send_word(32'h701, 32'h2, 1'b0, 1'b0, 1'b0, 3);
    RX_PEND = 1'b1;
    RX_REQ = 1'b1;
    tick(3);
    chk("rstmid_ack_pre", RX_ACK, 1);
    RESET = 1'b1;
    RX_REQ = 1'b0;
    tick(1);
    chk("rstmid_ack", RX_ACK, 0);
    chk("rstmid_valid", MSG_VALID, 0);
    chk("rstmid_wr", 64'(dut.wr), 0);
    chk("rstmid_rd", 64'(dut.rd), 0);
    RESET = 1'b0;
    tick(4);
    send_word(32'h800, 32'h55AA, 1'b0, 1'b1, 1'b1, 3);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
